// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: mode encoding
// and the chunk-width helper used to partition operands across stages.
package rca_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } rca_mode_e;

    function automatic int chunk_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// Combinational ripple of one operand chunk built from full_adder cells;
// also exposes the carry into the chunk MSB for signed-overflow detection.
module rca_chunk #(
    parameter int CW = 16
) (
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    input  logic          i_cin,
    output logic [CW-1:0] o_sum,
    output logic          o_cout,
    output logic          o_cmsb
);

    logic [CW:0] carry;

    assign carry[0] = i_cin;

    for (genvar i = 0; i < CW; i++) begin : g_bit
        full_adder u_fa (
            .a    (i_a[i]),
            .b    (i_b[i]),
            .cin  (carry[i]),
            .s    (o_sum[i]),
            .cout (carry[i+1])
        );
    end

    assign o_cout = carry[CW];
    assign o_cmsb = carry[CW-1];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined add/subtract: one chunk rippled per stage, with operand and sum
// skew registers so every result leaves the last stage fully aligned.
module rca_pipe
    import rca_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_overflow
);

    localparam int CW = chunk_width(WIDTH, STAGES);
    localparam int TW = WIDTH - (STAGES - 1) * CW;

    logic             advance;
    logic [WIDTH-1:0] term2_eff;
    logic             ovf_d, ovf_q;

    assign advance   = !o_valid || i_ready;
    assign o_ready   = advance;
    assign term2_eff = (i_sub == SUB) ? ~i_add_term2 : i_add_term2;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * CW;
        localparam int W  = (k == STAGES - 1) ? TW : CW;
        localparam int HI = LO + W;

        // Operand bits not yet consumed by earlier stages, LSB-aligned
        logic [WIDTH-LO-1:0] a_src, b_src;
        logic [W-1:0]        chunk_sum;
        logic                cin, cout, cmsb, sub_in, valid_in;
        logic [HI-1:0]       sum_d, sum_q;
        logic                carry_d, carry_q, sub_d, sub_q, valid_d, valid_q;

        if (k == 0) begin : g_head
            always_comb begin
                a_src    = i_add_term1;
                b_src    = term2_eff;
                cin      = i_sub;
                sub_in   = i_sub;
                valid_in = i_valid;
                sum_d    = chunk_sum;
            end
        end else begin : g_body
            always_comb begin
                a_src    = g_st[k-1].g_skew.a_q;
                b_src    = g_st[k-1].g_skew.b_q;
                cin      = g_st[k-1].carry_q;
                sub_in   = g_st[k-1].sub_q;
                valid_in = g_st[k-1].valid_q;
                sum_d    = {chunk_sum, g_st[k-1].sum_q};
            end
        end

        rca_chunk #(.CW(W)) u_chunk (
            .i_a    (a_src[W-1:0]),
            .i_b    (b_src[W-1:0]),
            .i_cin  (cin),
            .o_sum  (chunk_sum),
            .o_cout (cout),
            .o_cmsb (cmsb)
        );

        always_comb begin
            carry_d = cout;
            sub_d   = sub_in;
            valid_d = valid_in;
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sub_q   <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sub_q   <= sub_d;
                sum_q   <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-HI-1:0] a_d, a_q, b_d, b_q;
            // Carry into the MSB is only meaningful for the top chunk
            logic                cmsb_unused;

            assign cmsb_unused = cmsb;

            always_comb begin
                a_d = a_src[WIDTH-LO-1:W];
                b_d = b_src[WIDTH-LO-1:W];
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    always_comb begin
        ovf_d = g_st[STAGES-1].cout ^ g_st[STAGES-1].cmsb;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign o_valid    = g_st[STAGES-1].valid_q;
    assign o_result   = {g_st[STAGES-1].carry_q ^ g_st[STAGES-1].sub_q, g_st[STAGES-1].sum_q};
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_rca_pipe.sv
// Bench for rca_pipe: scoreboarded 64/4 instance plus latency/result checks
// on 55/4 and 64/1 configurations.
module tb_rca_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        m_valid, m_ready_o, m_sub, m_valid_o, m_ready_i, m_ovf;
    logic [63:0] m_a, m_b;
    logic [64:0] m_res;

    logic        n_valid, n_ready_o, n_sub, n_valid_o, n_ovf;
    logic [54:0] n_a, n_b;
    logic [55:0] n_res;

    logic        s_valid, s_ready_o, s_sub, s_valid_o, s_ovf;
    logic [63:0] s_a, s_b;
    logic [64:0] s_res;

    rca_pipe #(.WIDTH(64), .STAGES(4)) u_main (
        .i_clk(clk), .i_rst(rst), .i_valid(m_valid), .o_ready(m_ready_o),
        .i_add_term1(m_a), .i_add_term2(m_b), .i_sub(m_sub),
        .o_valid(m_valid_o), .i_ready(m_ready_i), .o_result(m_res), .o_overflow(m_ovf)
    );

    rca_pipe #(.WIDTH(55), .STAGES(4)) u_w55 (
        .i_clk(clk), .i_rst(rst), .i_valid(n_valid), .o_ready(n_ready_o),
        .i_add_term1(n_a), .i_add_term2(n_b), .i_sub(n_sub),
        .o_valid(n_valid_o), .i_ready(1'b1), .o_result(n_res), .o_overflow(n_ovf)
    );

    rca_pipe #(.WIDTH(64), .STAGES(1)) u_s1 (
        .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(s_ready_o),
        .i_add_term1(s_a), .i_add_term2(s_b), .i_sub(s_sub),
        .o_valid(s_valid_o), .i_ready(1'b1), .o_result(s_res), .o_overflow(s_ovf)
    );

    typedef struct {
        logic [64:0] res;
        logic        ovf;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   lat_chk = 1'b1;

    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic sub, input int c, input bit l);
        logic [63:0] be;
        logic [64:0] full;
        exp_t        r;
        be    = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, be} + {64'd0, sub};
        r.res = {full[64] ^ sub, full[63:0]};
        r.ovf = (a[63] == be[63]) && (full[63] != a[63]);
        r.cyc = c;
        r.lat = l;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready_o)
            sb.push_back(model(m_a, m_b, m_sub, cyc, lat_chk));
    end

    always @(negedge clk) begin
        if (!rst && m_valid_o && m_ready_i) begin
            n_vec++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_result got=%h expected=none", m_res);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                assert (m_res === e.res) else begin
                    n_err++;
                    $error("FAIL result got=%h expected=%h", m_res, e.res);
                end
                n_vec++;
                assert (m_ovf === e.ovf) else begin
                    n_err++;
                    $error("FAIL overflow got=%b expected=%b (res %h)", m_ovf, e.ovf, e.res);
                end
                if (e.lat) begin
                    n_vec++;
                    assert (cyc - e.cyc == 4) else begin
                        n_err++;
                        $error("FAIL latency got=%0d expected=4", cyc - e.cyc);
                    end
                end
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub);
        bit ok;
        ok      = 1'b0;
        m_valid = 1'b1;
        m_a     = a;
        m_b     = b;
        m_sub   = sub;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (m_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", {64'd0, ok}, 65'd1);
        @(posedge clk);
        #1;
        m_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        idle(2);
        chk("drain_empty", 65'(sb.size()), 65'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_n, lat_s;
        rst = 1'b1;
        m_valid = 0; m_a = '0; m_b = '0; m_sub = 0; m_ready_i = 1'b1;
        n_valid = 0; n_a = '0; n_b = '0; n_sub = 0;
        s_valid = 0; s_a = '0; s_b = '0; s_sub = 0;
        #2;
        chk("rst_o_valid", {64'd0, m_valid_o}, 65'd0);
        chk("rst_o_ready", {64'd0, m_ready_o}, 65'd1);
        chk("rst_o_result", m_res, 65'd0);
        chk("rst_o_overflow", {64'd0, m_ovf}, 65'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Carry, borrow and signed-overflow corners
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        send(64'h0, 64'h1, 1'b1);
        send(64'h8000_0000_0000_0000, 64'h1, 1'b1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        drain();

        // Bubbles between operations
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        idle(1);
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        idle(2);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        drain();

        // Eight back-to-back ops with a three-cycle downstream stall
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send({$urandom, $urandom}, {$urandom, $urandom}, i[0]);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                m_ready_i = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_o_ready", {64'd0, m_ready_o}, 65'd0);
                end
                @(posedge clk);
                #1;
                m_ready_i = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Reset with work in flight and a result at the output
        send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
        idle(2);
        send(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b1);
        chk("rst_pre_valid", {64'd0, m_valid_o}, 65'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {64'd0, m_valid_o}, 65'd0);
        chk("rst_async_ready", {64'd0, m_ready_o}, 65'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001, 1'b0);
        drain();

        // Narrow-width and single-stage configurations
        chk("w55_ready", {64'd0, n_ready_o}, 65'd1);
        chk("s1_ready", {64'd0, s_ready_o}, 65'd1);
        n_valid = 1'b1; n_a = '1; n_b = 55'd1; n_sub = 1'b0;
        s_valid = 1'b1; s_a = '1; s_b = 64'd1; s_sub = 1'b0;
        @(posedge clk);
        #1;
        n_valid = 1'b0;
        s_valid = 1'b0;
        lat_n = 0;
        lat_s = 0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (s_valid_o && lat_s == 0) begin
                lat_s = t;
                chk("s1_result", s_res, {1'b1, 64'h0});
                chk("s1_overflow", {64'd0, s_ovf}, 65'd0);
            end
            if (n_valid_o && lat_n == 0) begin
                lat_n = t;
                chk("w55_result", {9'd0, n_res}, {9'd0, 1'b1, 55'h0});
                chk("w55_overflow", {64'd0, n_ovf}, 65'd0);
            end
        end
        chk("w55_latency", 65'(lat_n), 65'd4);
        chk("s1_latency", 65'(lat_s), 65'd1);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rca_pipe.md
RCA_PIPE -- requirements
Module: rca_pipe

Interface
REQ-001 Parameter WIDTH, default 64: operand width in bits; SHALL be at least 2.
REQ-002 Parameter STAGES, default 4: number of pipeline stages; SHALL satisfy 1 <= STAGES <= WIDTH.
REQ-003 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset; asynchronous and active-high.
REQ-005 i_valid  input  1  the operand set on i_add_term1, i_add_term2 and i_sub is valid.
REQ-006 o_ready  output  1  the block accepts an operand set this cycle.
REQ-007 i_add_term1  input  WIDTH  first operand.
REQ-008 i_add_term2  input  WIDTH  second operand.
REQ-009 i_sub  input  1  mode: 0 = add, 1 = subtract (term1 - term2).
REQ-010 o_valid  output  1  o_result and o_overflow hold a valid result.
REQ-011 i_ready  input  1  downstream accepts the result this cycle.
REQ-012 o_result  output  WIDTH+1  bits [WIDTH-1:0] are the sum or difference; bit [WIDTH] is the carry-out (add) or the borrow (subtract).
REQ-013 o_overflow  output  1  two's-complement signed overflow of the operation.

Function
REQ-014 Operands SHALL be split into STAGES chunks of CW = ceil(WIDTH/STAGES) bits, LSB chunk first; the top chunk SHALL take the remaining WIDTH-(STAGES-1)*CW bits, and that count SHALL be at least 1.
REQ-015 Stage k SHALL ripple-add chunk k using the carry registered by stage k-1; stage 0 SHALL use carry-in = i_sub.
REQ-016 In subtract mode term2 SHALL be bit-inverted before addition; o_result[WIDTH] SHALL be the inverted final carry (1 = borrow).
REQ-017 Not-yet-consumed upper chunks and completed lower sum chunks SHALL travel in skew registers so that each result exits aligned.
REQ-018 The stall enable SHALL be: advance = !o_valid || i_ready; o_ready SHALL equal advance.
REQ-019 When advance is 1, every stage SHALL shift one position, and stage 0 SHALL capture valid = i_valid.
REQ-020 When advance is 0, all stage registers, o_result, o_overflow and o_valid SHALL hold.
REQ-021 Latency SHALL be exactly STAGES cycles from an accepted input (i_valid && o_ready) to o_valid, with no stall in between.
REQ-022 Throughput SHALL be one operation per cycle with i_ready held high.
REQ-023 Bubbles (i_valid=0) SHALL propagate as invalid entries; valid data SHALL never be dropped, duplicated or reordered.
REQ-024 o_overflow SHALL be the XOR of the carry into and the carry out of bit WIDTH-1.
REQ-025 When o_valid is 0, o_result and o_overflow are don't-care; the bench SHALL NOT check them.
REQ-026 With STAGES=1 the block SHALL behave as a single registered ripple adder with latency 1.

Reset
REQ-027 Asserting i_rst SHALL clear all stage valid bits and o_valid immediately, without waiting for a clock edge.
REQ-028 Asserting i_rst SHALL set o_result, o_overflow and all data and carry registers to 0.
REQ-029 Operations in flight when i_rst asserts SHALL be discarded and never emitted.
REQ-030 o_ready SHALL be 1 during and after reset, since o_valid=0.
REQ-031 The first input SHALL be accepted on the first rising edge after i_rst deasserts.

Structure
REQ-032 A shared package rca_pkg SHALL hold the mode encodings (ADD=0, SUB=1) and a constant function that returns the chunk width for given WIDTH and STAGES.
REQ-033 One sub-module, rca_chunk, SHALL implement the combinational ripple of one chunk (parameter CW, carry in, carry out, and carry into its MSB).
REQ-034 rca_chunk SHALL reuse the existing full_adder cell.
REQ-035 rca_pipe SHALL instantiate rca_chunk once per stage with a generate loop.

Verification (WIDTH=64, STAGES=4)
REQ-036 Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> o_result = {1, 0x0}, o_overflow = 0, exactly 4 cycles later.
REQ-037 Subtract 0x0 - 0x1 -> o_result = {1, 0xFFFF_FFFF_FFFF_FFFF}, o_overflow = 0; subtract 0x8000_0000_0000_0000 - 0x1 -> o_overflow = 1.
REQ-038 Add 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> o_result[63:0] = 0x8000_0000_0000_0000, o_overflow = 1, carry = 0.
REQ-039 Issue 8 back-to-back mixed add/sub ops and hold i_ready low on cycles 5-7 -> all 8 results emerge in order and match the reference model; o_ready = 0 while stalled.
REQ-040 Issue 3 ops, assert i_rst for 1 cycle after the 2nd -> o_valid drops immediately, no stale result appears, and the next op completes normally.
REQ-041 Repeat REQ-036 with WIDTH=55, STAGES=4 (CW=14, top chunk 13 bits) and with STAGES=1 -> correct results at latency 4 and 1 respectively.
